mouse_decoder: RTL and testbench



---
 rtl/mouse_decoder_pkg.sv | 38 +++
 rtl/mouse_decoder_if.sv | 27 ++
 rtl/mouse_decoder_ps2_rx_byte.sv | 81 ++++++++
 rtl/mouse_decoder.sv | 113 +++++++++++
 tb/tb_mouse_decoder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_decoder_pkg.sv
// Shared constants, byte0 field positions and packet FSM encoding for the PS/2 mouse front end.
package mouse_decoder_pkg;

    localparam int SCREEN_W_DEF    = 800;
    localparam int SCREEN_H_DEF    = 600;
    localparam int X_INIT_DEF      = 400;
    localparam int Y_INIT_DEF      = 300;
    localparam int TIMEOUT_CYC_DEF = 4000;

    localparam int PS2_FRAME_LEN = 11;

    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_ALIGN = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2
    } pkt_state_t;

    // Saturate a 13-bit signed position into 0..limit-1.
    function automatic logic [11:0] clamp_axis(input logic signed [12:0] v, input int limit);
        logic signed [12:0] lim;
        lim = 13'(limit - 1);
        if (v[12])
            return 12'd0;
        else if (v > lim)
            return 12'(limit - 1);
        else
            return v[11:0];
    endfunction

endpackage

// File: rtl/mouse_decoder_if.sv
// Pins and cursor outputs of the mouse decoder, plus the packet FSM state for observation.
interface mouse_decoder_if;
    import mouse_decoder_pkg::*;

    // Handshake: mouse_valid and rx_error are single-cycle strobes with no ready;
    // the consumer samples position/buttons whenever mouse_valid is high, otherwise they hold.
    logic        ps2_clk;
    logic        ps2_data;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        mouse_right;
    logic        mouse_valid;
    logic        rx_error;
    pkt_state_t  pkt_state;

    modport master (
        output ps2_clk, ps2_data,
        input  mouse_xpos, mouse_ypos, mouse_left, mouse_right, mouse_valid, rx_error, pkt_state
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output mouse_xpos, mouse_ypos, mouse_left, mouse_right, mouse_valid, rx_error, pkt_state
    );

endinterface

// File: rtl/mouse_decoder_ps2_rx_byte.sv
// PS/2 byte receiver: pin synchronisers, falling-edge strobe, 11-bit frame shift/check, idle timeout.
module ps2_rx_byte
    import mouse_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       rx_error,
    output logic       timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          fall, fall_data;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            clk_prev  <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            fall      <= 1'b0;
            fall_data <= 1'b1;
            bit_cnt   <= 4'd0;
            shreg     <= 9'd0;
            idle_cnt  <= '0;
            byte_done <= 1'b0;
            rx_byte   <= 8'd0;
            rx_error  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            clk_prev  <= clk_s2;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            fall      <= clk_prev & ~clk_s2;
            fall_data <= dat_s2;
            byte_done <= 1'b0;
            rx_error  <= 1'b0;
            timeout   <= 1'b0;
            // An edge always restarts the idle count, so it beats a same-cycle timeout.
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!fall_data)
                        bit_cnt <= 4'd1;
                end else if (bit_cnt == 4'(PS2_FRAME_LEN - 1)) begin
                    bit_cnt <= 4'd0;
                    if (fall_data && (^shreg)) begin
                        byte_done <= 1'b1;
                        rx_byte   <= shreg[7:0];
                    end else begin
                        rx_error <= 1'b1;
                    end
                end else begin
                    shreg   <= {fall_data, shreg[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (idle_cnt != TW'(TIMEOUT_CYC)) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    timeout <= 1'b1;
                    bit_cnt <= 4'd0;
                end
            end
        end
    end

endmodule

// File: rtl/mouse_decoder.sv
// PS/2 mouse front end: assembles 3-byte stream packets and integrates deltas into a clamped cursor.
module mouse_decoder
    import mouse_decoder_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int X_INIT      = X_INIT_DEF,
    parameter int Y_INIT      = Y_INIT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            pclk,
    input  logic            reset,
    mouse_decoder_if.slave  bus
);

    logic       byte_done, rx_error, timeout;
    logic [7:0] rx_byte;

    ps2_rx_byte #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .pclk      (pclk),
        .reset     (reset),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .rx_error  (rx_error),
        .timeout   (timeout)
    );

    pkt_state_t         state;
    logic               p_left, p_right, p_xsign, p_ysign, p_xovf, p_yovf;
    logic [7:0]         p_dx;
    logic               acc_valid, acc_left, acc_right;
    logic signed [12:0] nx, ny;
    logic signed [12:0] dx_ext, dy_ext;
    logic [11:0]        xpos, ypos;
    logic               left, right, valid;

    // byte2 is still on rx_byte when the sum is taken, so dy comes straight from it.
    assign dx_ext = p_xovf ? 13'sd0 : {{5{p_xsign}}, p_dx};
    assign dy_ext = p_yovf ? 13'sd0 : {{5{p_ysign}}, rx_byte};

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state     <= BYTE0;
            p_left    <= 1'b0;
            p_right   <= 1'b0;
            p_xsign   <= 1'b0;
            p_ysign   <= 1'b0;
            p_xovf    <= 1'b0;
            p_yovf    <= 1'b0;
            p_dx      <= 8'd0;
            acc_valid <= 1'b0;
            acc_left  <= 1'b0;
            acc_right <= 1'b0;
            nx        <= 13'sd0;
            ny        <= 13'sd0;
            xpos      <= 12'(X_INIT);
            ypos      <= 12'(Y_INIT);
            left      <= 1'b0;
            right     <= 1'b0;
            valid     <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            valid     <= 1'b0;
            if (rx_error || timeout) begin
                state <= BYTE0;
            end else if (byte_done) begin
                case (state)
                    BYTE0: if (rx_byte[B0_ALIGN]) begin
                        p_left  <= rx_byte[B0_LEFT];
                        p_right <= rx_byte[B0_RIGHT];
                        p_xsign <= rx_byte[B0_XSIGN];
                        p_ysign <= rx_byte[B0_YSIGN];
                        p_xovf  <= rx_byte[B0_XOVF];
                        p_yovf  <= rx_byte[B0_YOVF];
                        state   <= BYTE1;
                    end
                    BYTE1: begin
                        p_dx  <= rx_byte;
                        state <= BYTE2;
                    end
                    BYTE2: begin
                        // PS/2 y grows upward; the screen grows downward.
                        nx        <= $signed({1'b0, xpos}) + dx_ext;
                        ny        <= $signed({1'b0, ypos}) - dy_ext;
                        acc_left  <= p_left;
                        acc_right <= p_right;
                        acc_valid <= 1'b1;
                        state     <= BYTE0;
                    end
                    default: state <= BYTE0;
                endcase
            end
            if (acc_valid) begin
                xpos  <= clamp_axis(nx, SCREEN_W);
                ypos  <= clamp_axis(ny, SCREEN_H);
                left  <= acc_left;
                right <= acc_right;
                valid <= 1'b1;
            end
        end
    end

    assign bus.mouse_xpos  = xpos;
    assign bus.mouse_ypos  = ypos;
    assign bus.mouse_left  = left;
    assign bus.mouse_right = right;
    assign bus.mouse_valid = valid;
    assign bus.rx_error    = rx_error;
    assign bus.pkt_state   = state;

endmodule

// File: tb/tb_mouse_decoder.sv
// Randomised and directed PS/2 packet stimulus against a behavioural cursor model with a scoreboard.
module tb_mouse_decoder;
  import mouse_decoder_pkg::*;

  localparam int HALF    = 20;
  localparam int GAP     = 30;
  localparam int TIMEOUT = 4000;

  logic pclk;
  logic reset;
  int   cyc;
  int   checks;
  int   passes;

  mouse_decoder_if bus();

  mouse_decoder dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // scoreboard: {valid cycle, x, y, left, right}
  logic [57:0] exp_q[$];
  int          err_q[$];

  int   mx, my;
  logic ml, mr;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b);
    if (bad_par) par = ~par;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Reference: apply one complete packet to the model cursor.
  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int edge_cyc);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clampi(mx + dx, 799);
    my = clampi(my - dy, 599);
    ml = b0[0];
    mr = b0[1];
    exp_q.push_back({32'(edge_cyc + 6), 12'(mx), 12'(my), ml, mr});
  endtask

  // driver tasks
  task automatic ps2_release();
    repeat (HALF) @(posedge pclk);
    #1 bus.ps2_clk = 1'b1;
  endtask

  // Leaves ps2_clk low after the last bit's falling edge so the caller can log expectations first.
  task automatic ps2_bits(input logic [10:0] frame, input int nbits, output int edge_cyc);
    edge_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) ps2_release();
      @(posedge pclk);
      #1 bus.ps2_data = frame[i];
      repeat (HALF) @(posedge pclk);
      #1 bus.ps2_clk = 1'b0;
      edge_cyc = cyc;
    end
  endtask

  task automatic gap();
    bus.ps2_data = 1'b1;
    repeat (GAP) @(posedge pclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    int c;
    ps2_bits(make_frame(b, bad_par), 11, c);
    if (bad_par) err_q.push_back(c + 4);
    ps2_release();
    gap();
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int c;
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    ps2_bits(make_frame(b2, 1'b0), 11, c);
    model_packet(b0, b1, b2, c);
    ps2_release();
    gap();
  endtask

  task automatic check_out(input string name, input int x, input int y, input logic l, input logic r);
    @(negedge pclk);
    checks++;
    if (bus.mouse_xpos == 12'(x) && bus.mouse_ypos == 12'(y) && bus.mouse_left == l && bus.mouse_right == r)
      passes++;
    else
      $display("FAIL %s: got x=%0d y=%0d l=%0d r=%0d, want x=%0d y=%0d l=%0d r=%0d", name,
               bus.mouse_xpos, bus.mouse_ypos, bus.mouse_left, bus.mouse_right, x, y, l, r);
  endtask

  task automatic do_reset();
    @(posedge pclk);
    #1 reset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;
    mx = 400; my = 300; ml = 1'b0; mr = 1'b0;
  endtask

  // monitor
  always @(negedge pclk) begin
    if (!reset) begin
      if (bus.mouse_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: cyc=%0d x=%0d y=%0d", cyc, bus.mouse_xpos, bus.mouse_ypos);
        end else begin
          logic [57:0] e, g;
          e = exp_q.pop_front();
          g = {32'(cyc), bus.mouse_xpos, bus.mouse_ypos, bus.mouse_left, bus.mouse_right};
          if (g == e) passes++;
          else
            $display("FAIL packet_apply: got cyc=%0d x=%0d y=%0d l=%0d r=%0d, want cyc=%0d x=%0d y=%0d l=%0d r=%0d",
                     g[57:26], g[25:14], g[13:2], g[1], g[0], e[57:26], e[25:14], e[13:2], e[1], e[0]);
        end
      end
      if (bus.rx_error) begin
        checks++;
        if (err_q.size() == 0) begin
          $display("FAIL unexpected_rx_error: cyc=%0d", cyc);
        end else begin
          int ec;
          ec = err_q.pop_front();
          if (cyc == ec) passes++;
          else $display("FAIL rx_error_timing: got cyc=%0d, want cyc=%0d", cyc, ec);
        end
      end
    end
  end

  // stimulus
  initial begin
    int c;
    logic [7:0] b0, b1, b2;
    cyc = 0; checks = 0; passes = 0;
    reset = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    mx = 400; my = 300; ml = 1'b0; mr = 1'b0;
    repeat (5) @(posedge pclk);
    #1 reset = 1'b0;
    check_out("reset_state", 400, 300, 1'b0, 1'b0);
    repeat (10000) @(posedge pclk);
    check_out("idle_hold", 400, 300, 1'b0, 1'b0);

    send_packet(8'h09, 8'h10, 8'h00);
    check_out("dx_plus16_left", 416, 300, 1'b1, 1'b0);
    send_packet(8'h28, 8'h00, 8'hF6);
    check_out("dy_minus10", 416, 310, 1'b0, 1'b0);
    send_packet(8'h08, 8'hFF, 8'h00);
    send_packet(8'h08, 8'h77, 8'h00);
    check_out("x_at_790", 790, 310, 1'b0, 1'b0);
    send_packet(8'h08, 8'h14, 8'h00);
    check_out("clamp_high", 799, 310, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_packet(8'h18, 8'h00, 8'h00);
    send_packet(8'h18, 8'hE6, 8'h00);
    check_out("x_at_5", 5, 310, 1'b0, 1'b0);
    send_packet(8'h18, 8'h00, 8'h00);
    check_out("clamp_low", 0, 310, 1'b0, 1'b0);

    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    check_out("parity_no_update", 0, 310, 1'b0, 1'b0);
    send_packet(8'h08, 8'h01, 8'h01);
    check_out("after_parity_error", 1, 309, 1'b0, 1'b0);

    send_byte(8'h00, 1'b0);
    send_packet(8'h08, 8'h02, 8'h00);
    check_out("misaligned_skip", 3, 309, 1'b0, 1'b0);

    ps2_bits(make_frame(8'h5A, 1'b0), 5, c);
    ps2_release();
    repeat (TIMEOUT + 200) @(posedge pclk);
    send_packet(8'h0A, 8'h04, 8'h00);
    check_out("frame_timeout", 7, 309, 1'b0, 1'b1);

    send_byte(8'h09, 1'b0);
    repeat (TIMEOUT + 200) @(posedge pclk);
    send_packet(8'h08, 8'h10, 8'h10);
    check_out("packet_timeout", 23, 293, 1'b0, 1'b0);

    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    do_reset();
    check_out("reset_mid_packet", 400, 300, 1'b0, 1'b0);
    send_packet(8'h08, 8'h03, 8'h02);
    check_out("after_reset_packet", 403, 298, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      b0 = 8'($urandom_range(0, 255)) | 8'h08;
      if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      send_packet(b0, b1, b2);
    end
    check_out("random_final", mx, my, ml, mr);

    repeat (50) @(posedge pclk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL missing_valid: %0d packets never applied", exp_q.size());
    checks++;
    if (err_q.size() == 0) passes++;
    else $display("FAIL missing_rx_error: %0d errors never reported", err_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
